// File: rtl/vram_write_port.sv
// Shadow video RAM (pages 5 and 7) fed by a CPU write queue; video fetches have priority.
// Define VRAM_WBYPASS_EN to let video reads see the newest still-queued write to the same address.
module vram_write_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        nMREQ,
    input  logic        nWR,
    input  logic        m128,
    input  logic [2:0]  page_ram,
    input  logic        vram_rd,
    input  logic [14:0] vram_addr,
    output logic [7:0]  vram_dout,
    output logic        q_full,
    output logic        q_ovf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    r_ram [32768];
    logic [14:0]   r_fifo_addr [DEPTH];
    logic [7:0]    r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_wr_prev;

    logic          w_wr;
    logic          w_hit;
    logic [14:0]   w_cap_addr;
    logic          w_capture;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_rd_data;

    assign w_wr = ~nMREQ & ~nWR;

    // Map CPU address to shadow RAM: 4000-7FFF is always page 5, C000-FFFF follows the 128K pager.
    always_comb begin
        w_hit      = 1'b0;
        w_cap_addr = {1'b0, addr[13:0]};
        if (addr[15:14] == 2'b01) begin
            w_hit = 1'b1;
        end else if (addr[15:14] == 2'b11 && m128) begin
            if (page_ram == 3'd5) begin
                w_hit = 1'b1;
            end else if (page_ram == 3'd7) begin
                w_hit      = 1'b1;
                w_cap_addr = {1'b1, addr[13:0]};
            end
        end
    end

    assign w_capture = w_wr & ~r_wr_prev & w_hit;
    assign w_pop     = ~vram_rd & (r_count != '0);
    assign w_push    = w_capture & ((r_count != FULL_CNT) | w_pop);
    assign q_full    = (r_count == FULL_CNT);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_prev <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            q_ovf     <= 1'b0;
        end else begin
            r_wr_prev <= w_wr;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_capture && !w_push) begin
                q_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_cap_addr;
            r_fifo_data[r_wptr] <= din;
        end
    end

    // Single RAM port: a pop can only happen when no video read is in progress.
    always_ff @(posedge clk_sys) begin
        if (w_pop) begin
            r_ram[r_fifo_addr[r_rptr]] <= r_fifo_data[r_rptr];
        end
    end

`ifdef VRAM_WBYPASS_EN
    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_rd_data = r_ram[vram_addr];
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PW'(i);
            if (i < int'(r_count) && r_fifo_addr[idx] == vram_addr) begin
                w_rd_data = r_fifo_data[idx];
            end
        end
    end
`else
    assign w_rd_data = r_ram[vram_addr];
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vram_dout <= 8'h00;
        end else if (vram_rd) begin
            vram_dout <= w_rd_data;
        end
    end
endmodule

// File: tb/tb_vram_write_port.sv
// Directed bench for vram_write_port: table of write/read vectors plus hand-built queue sequences.
module tb_vram_write_port;
    logic        clk_sys;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        nMREQ;
    logic        nWR;
    logic        m128;
    logic [2:0]  page_ram;
    logic        vram_rd;
    logic [14:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        q_full;
    logic        q_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        m;
        logic [2:0]  pg;
        logic [14:0] ra;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[10];

    vram_write_port #(.DEPTH(4)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .addr      (addr),
        .din       (din),
        .nMREQ     (nMREQ),
        .nWR       (nWR),
        .m128      (m128),
        .page_ram  (page_ram),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .q_full    (q_full),
        .q_ovf     (q_ovf)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One CPU write cycle: strobes low for one clock edge, then released.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic m, input logic [2:0] pg);
        @(negedge clk_sys);
        addr = a; din = d; m128 = m; page_ram = pg;
        nMREQ = 1'b0; nWR = 1'b0;
        @(negedge clk_sys);
        nMREQ = 1'b1; nWR = 1'b1;
    endtask

    task automatic video_read(input logic [14:0] ra, output logic [7:0] d);
        @(negedge clk_sys);
        vram_rd = 1'b1; vram_addr = ra;
        @(posedge clk_sys);
        #1 d = vram_dout;
        @(negedge clk_sys);
        vram_rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [14:0] ra, input logic [7:0] exp);
        logic [7:0] d;
        video_read(ra, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b0; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1;
        m128 = 1'b0; page_ram = '0; vram_rd = 1'b0; vram_addr = '0;

        vecs[0] = '{16'h4000, 8'h5A, 1'b0, 3'd0, 15'h0000, 8'h5A};
        vecs[1] = '{16'hC010, 8'hC3, 1'b1, 3'd7, 15'h4010, 8'hC3};
        vecs[2] = '{16'hC010, 8'h77, 1'b1, 3'd3, 15'h4010, 8'hC3};
        vecs[3] = '{16'hC020, 8'h99, 1'b1, 3'd5, 15'h0020, 8'h99};
        vecs[4] = '{16'hC020, 8'h44, 1'b0, 3'd5, 15'h0020, 8'h99};
        vecs[5] = '{16'h8000, 8'h12, 1'b1, 3'd5, 15'h0000, 8'h5A};
        vecs[6] = '{16'h0000, 8'h34, 1'b1, 3'd5, 15'h0000, 8'h5A};
        vecs[7] = '{16'h7FFF, 8'hE1, 1'b0, 3'd0, 15'h3FFF, 8'hE1};
        vecs[8] = '{16'hFFFF, 8'h0F, 1'b1, 3'd7, 15'h7FFF, 8'h0F};
        vecs[9] = '{16'h4000, 8'hA5, 1'b0, 3'd0, 15'h0000, 8'hA5};

        #3 reset = 1'b1;
        #1;
        check("reset_dout", vram_dout, 8'h00);
        check("reset_full", {7'd0, q_full}, 8'h00);
        check("reset_ovf", {7'd0, q_ovf}, 8'h00);
        @(negedge clk_sys);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cpu_write(vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].pg);
            repeat (3) @(negedge clk_sys);
            video_read(vecs[i].ra, d);
            check($sformatf("vec%0d_read", i), d, vecs[i].exp);
            repeat (2) @(negedge clk_sys);
            check($sformatf("vec%0d_hold", i), vram_dout, vecs[i].exp);
            check($sformatf("vec%0d_ovf", i), {7'd0, q_ovf}, 8'h00);
        end

        // Fill under continuous video reads, overflow once, then drain in order.
        do_reset();
        cpu_write(16'h4204, 8'hEE, 1'b0, 3'd0);
        repeat (3) @(negedge clk_sys);
        vram_rd = 1'b1; vram_addr = 15'h2000;
        cpu_write(16'h4200, 8'hB0, 1'b0, 3'd0);
        cpu_write(16'h4201, 8'hB1, 1'b0, 3'd0);
        cpu_write(16'h4200, 8'hB2, 1'b0, 3'd0);
        check("fill3_full", {7'd0, q_full}, 8'h00);
        cpu_write(16'h4202, 8'hB3, 1'b0, 3'd0);
        check("fill4_full", {7'd0, q_full}, 8'h01);
        check("fill4_ovf", {7'd0, q_ovf}, 8'h00);
        cpu_write(16'h4204, 8'hB4, 1'b0, 3'd0);
        check("drop_ovf", {7'd0, q_ovf}, 8'h01);
        check("drop_full", {7'd0, q_full}, 8'h01);
        vram_rd = 1'b0;
        @(posedge clk_sys);
        #1 check("first_pop_full", {7'd0, q_full}, 8'h00);
        repeat (5) @(negedge clk_sys);
        read_check("drain_0200", 15'h0200, 8'hB2);
        read_check("drain_0201", 15'h0201, 8'hB1);
        read_check("drain_0202", 15'h0202, 8'hB3);
        read_check("dropped_0204", 15'h0204, 8'hEE);
        check("ovf_sticky", {7'd0, q_ovf}, 8'h01);

        // Capture while full coincides with a pop: accepted, occupancy stays at 4.
        do_reset();
        vram_rd = 1'b1; vram_addr = 15'h2000;
        cpu_write(16'h4300, 8'hC0, 1'b0, 3'd0);
        cpu_write(16'h4301, 8'hC1, 1'b0, 3'd0);
        cpu_write(16'h4302, 8'hC2, 1'b0, 3'd0);
        cpu_write(16'h4303, 8'hC3, 1'b0, 3'd0);
        check("pp_full_before", {7'd0, q_full}, 8'h01);
        @(negedge clk_sys);
        vram_rd = 1'b0; addr = 16'h4304; din = 8'hC4; nMREQ = 1'b0; nWR = 1'b0;
        @(posedge clk_sys);
        #1;
        check("pp_full_after", {7'd0, q_full}, 8'h01);
        check("pp_ovf", {7'd0, q_ovf}, 8'h00);
        @(negedge clk_sys);
        vram_rd = 1'b1; nMREQ = 1'b1; nWR = 1'b1;
        @(posedge clk_sys);
        #1 check("pp_full_held", {7'd0, q_full}, 8'h01);
        @(negedge clk_sys);
        vram_rd = 1'b0;
        repeat (6) @(negedge clk_sys);
        read_check("pp_0300", 15'h0300, 8'hC0);
        read_check("pp_0303", 15'h0303, 8'hC3);
        read_check("pp_0304", 15'h0304, 8'hC4);
        check("pp_ovf_end", {7'd0, q_ovf}, 8'h00);

        // Two queued writes to one address, read while still pending.
        do_reset();
        cpu_write(16'h4100, 8'h5C, 1'b0, 3'd0);
        repeat (3) @(negedge clk_sys);
        vram_rd = 1'b1; vram_addr = 15'h0100;
        cpu_write(16'h4100, 8'h11, 1'b0, 3'd0);
        cpu_write(16'h4100, 8'h22, 1'b0, 3'd0);
        @(posedge clk_sys);
        #1;
`ifdef VRAM_WBYPASS_EN
        check("pending_read", vram_dout, 8'h22);
`else
        check("pending_read", vram_dout, 8'h5C);
`endif
        @(negedge clk_sys);
        vram_rd = 1'b0;
        repeat (4) @(negedge clk_sys);
        read_check("after_drain_0100", 15'h0100, 8'h22);

        // Reset with three entries pending: outputs clear at once, entries are discarded.
        do_reset();
        cpu_write(16'h4400, 8'h01, 1'b0, 3'd0);
        cpu_write(16'h4401, 8'h02, 1'b0, 3'd0);
        cpu_write(16'h4402, 8'h03, 1'b0, 3'd0);
        repeat (4) @(negedge clk_sys);
        vram_rd = 1'b1; vram_addr = 15'h0400;
        cpu_write(16'h4400, 8'hD0, 1'b0, 3'd0);
        cpu_write(16'h4401, 8'hD1, 1'b0, 3'd0);
        cpu_write(16'h4402, 8'hD2, 1'b0, 3'd0);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check("rst_dout", vram_dout, 8'h00);
        check("rst_full", {7'd0, q_full}, 8'h00);
        check("rst_ovf", {7'd0, q_ovf}, 8'h00);
        repeat (2) @(negedge clk_sys);
        check("rst_read_ignored", vram_dout, 8'h00);
        vram_rd = 1'b0;
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        read_check("rst_0400", 15'h0400, 8'h01);
        read_check("rst_0401", 15'h0401, 8'h02);
        read_check("rst_0402", 15'h0402, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_write_port.md
VRAM_WRITE_PORT -- requirements
Module: vram_write_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk_sys  input  1  master clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  16  CPU address bus.
REQ-005 SHALL have port din  input  8  CPU write data.
REQ-006 SHALL have port nMREQ  input  1  CPU memory request, active low.
REQ-007 SHALL have port nWR  input  1  CPU write strobe, active low.
REQ-008 SHALL have port m128  input  1  128K paging enabled.
REQ-009 SHALL have port page_ram  input  3  RAM page mapped at C000-FFFF.
REQ-010 SHALL have port vram_rd  input  1  video fetch slot; the video controller reads in this cycle.
REQ-011 SHALL have port vram_addr  input  15  video fetch address; bit 14 selects page 7 (1) or page 5 (0).
REQ-012 SHALL have port vram_dout  output  8  video fetch data.
REQ-013 SHALL have port q_full  output  1  write queue full.
REQ-014 SHALL have port q_ovf  output  1  sticky write-dropped flag.

Function
REQ-015 SHALL hold a 32 KB single-port shadow RAM: bytes 0000-3FFF = page 5, 4000-7FFF = page 7.
REQ-016 SHALL detect a CPU write on the first clk_sys cycle where (~nMREQ & ~nWR) is 1 after being 0; exactly one capture per write cycle.
REQ-017 SHALL capture addr 4000-7FFF as page 5; addr C000-FFFF with m128=1 and page_ram=5 as page 5, page_ram=7 as page 7; ignore all other writes.
REQ-018 SHALL push each captured write, as {15-bit RAM address, 8-bit data}, into a FIFO of DEPTH entries.
REQ-019 SHALL, when vram_rd=1, read RAM at vram_addr, present data on vram_dout on the next clk_sys edge, and hold it until the next read.
REQ-020 SHALL, when vram_rd=0 and FIFO not empty, pop the head entry and write it to RAM that cycle; at most one RAM access per cycle; video reads always win.
REQ-021 SHALL allow push and pop in the same cycle; occupancy stays unchanged.
REQ-022 SHALL assert q_full combinationally from occupancy == DEPTH.
REQ-023 SHALL, on capture with FIFO full and no pop that cycle, drop the write, keep queue contents unchanged and set q_ovf; a same-cycle pop makes room and the write is accepted.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; the occupancy counter is one bit wider than the pointers.
REQ-025 SHALL preserve FIFO order: a later write to the same address overwrites an earlier one in RAM.

Reset
REQ-026 SHALL, on reset, immediately clear FIFO pointers and occupancy, q_ovf=0, q_full=0, vram_dout=0, edge-detect state=0.
REQ-027 SHALL discard writes queued at reset assertion; RAM contents are not cleared.
REQ-028 SHALL ignore captures and reads while reset=1.

Configuration
REQ-029 SHALL, with VRAM_WBYPASS_EN defined, return on a video read the data of the newest queued entry whose address equals vram_addr, otherwise RAM data.
REQ-030 SHALL, without VRAM_WBYPASS_EN, return RAM data only; pending queued writes are not visible to reads.

Verification
REQ-031 SHALL cover: write 0x5A to 0x4000 with vram_rd=0 throughout, then read vram_addr=0x0000 -> vram_dout=0x5A one cycle after the read.
REQ-032 SHALL cover: m128=1, page_ram=7, write 0xC3 to 0xC010, then read vram_addr=0x4010 -> 0xC3; same write with page_ram=3 -> RAM unchanged, no push.
REQ-033 SHALL cover: vram_rd held 1 while 4 writes are captured (DEPTH=4) -> q_full=1; a 5th capture -> dropped, q_ovf=1; after vram_rd drops, the 4 entries drain in 4 cycles in order.
REQ-034 SHALL cover: FIFO full, vram_rd=0, capture in the same cycle as a pop -> accepted, q_ovf stays 0, occupancy stays 4.
REQ-035 SHALL cover: with VRAM_WBYPASS_EN, queue 0x11 then 0x22 to 0x4100 under vram_rd=1, then read vram_addr=0x0100 -> 0x22; without the macro -> old RAM value.
REQ-036 SHALL cover: reset asserted with 3 entries queued -> q_full=0, q_ovf=0, vram_dout=0 with no clock edge; no queued entry reaches RAM afterwards.
